// File: rtl/amo_bank_arbiter.sv
// amo_bank_arbiter
//   Round-robin arbiter that shares one AMO-capable SRAM bank between NumIn
//   requesters. It sits directly in front of the bank's atomic shim. Responses
//   come back one cycle after the grant and are routed to the requester that
//   owns them.
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   in_req_i         per-requester request
//   in_gnt_o         per-requester grant (one-hot or zero)
//   in_add_i         per-requester word address
//   in_amo_i         per-requester AMO opcode (0 = plain access)
//   in_wen_i         per-requester write enable (1 = store)
//   in_wdata_i       per-requester write data
//   in_be_i          per-requester byte enables
//   in_rvalid_o      per-requester response valid (one-hot or zero)
//   in_rdata_o       response data, shared by all requesters
//   out_req_o        request to the shim
//   out_gnt_i        grant from the shim (held low during an AMO commit)
//   out_add_o        address to the shim
//   out_amo_o        AMO opcode to the shim
//   out_wen_o        write enable to the shim
//   out_wdata_o      write data to the shim
//   out_be_o         byte enables to the shim
//   out_rdata_i      read data from the shim
//
// Optional build macro: AMO_BANK_ARB_PERF_EN
//   Adds perf_grants_o (completed handshakes) and perf_stalls_o (cycles with
//   out_req_o high and out_gnt_i low). Both saturate at all-ones.

module amo_bank_arbiter #(
  parameter int unsigned NumIn        = 4,
  parameter int unsigned AddrMemWidth = 32,
  parameter int unsigned DataWidth    = 64,
  localparam int unsigned IdxWidth    = (NumIn > 1) ? $clog2(NumIn) : 1,
  localparam int unsigned BeWidth     = DataWidth / 8
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NumIn-1:0]                        in_req_i,
  output logic [NumIn-1:0]                        in_gnt_o,
  input  logic [NumIn-1:0][AddrMemWidth-1:0]      in_add_i,
  input  logic [NumIn-1:0][3:0]                   in_amo_i,
  input  logic [NumIn-1:0]                        in_wen_i,
  input  logic [NumIn-1:0][DataWidth-1:0]         in_wdata_i,
  input  logic [NumIn-1:0][BeWidth-1:0]           in_be_i,
  output logic [NumIn-1:0]                        in_rvalid_o,
  output logic [DataWidth-1:0]                    in_rdata_o,
  output logic                                    out_req_o,
  input  logic                                    out_gnt_i,
  output logic [AddrMemWidth-1:0]                 out_add_o,
  output logic [3:0]                              out_amo_o,
  output logic                                    out_wen_o,
  output logic [DataWidth-1:0]                    out_wdata_o,
  output logic [BeWidth-1:0]                      out_be_o,
  input  logic [DataWidth-1:0]                    out_rdata_i
`ifdef AMO_BANK_ARB_PERF_EN
  ,
  output logic [31:0]                             perf_grants_o,
  output logic [31:0]                             perf_stalls_o
`endif
);

  typedef struct packed {
    logic [AddrMemWidth-1:0] add;
    logic [3:0]              amo;
    logic                    wen;
    logic [DataWidth-1:0]    wdata;
    logic [BeWidth-1:0]      be;
  } req_t;

  typedef enum logic {Idle, AmoCommit} state_e;

  localparam logic [IdxWidth:0] NUM_IN_W = NumIn[IdxWidth:0];

  req_t [NumIn-1:0]    lane_req;
  req_t                win_req;
  logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxWidth-1:0] rsp_idx_q, rsp_idx_d;
  logic                rvalid_q, rvalid_d;
  state_e              state_q, state_d;
  logic [IdxWidth-1:0] win_idx;
  logic                found;
  logic                hs;
  logic [IdxWidth:0]   ptr_inc;

  // Pack each requester's fields into one request word.
  for (genvar l = 0; l < NumIn; l++) begin : g_lane
    assign lane_req[l] = '{add:   in_add_i[l],
                           amo:   in_amo_i[l],
                           wen:   in_wen_i[l],
                           wdata: in_wdata_i[l],
                           be:    in_be_i[l]};
  end

  // Round-robin search: first requesting index at or after rr_ptr_q, wrapping.
  always_comb begin
    logic [IdxWidth:0] sum;
    win_idx = rr_ptr_q;
    found   = 1'b0;
    sum     = '0;
    for (int i = 0; i < NumIn; i++) begin
      sum = {1'b0, rr_ptr_q} + (IdxWidth+1)'(i);
      if (sum >= NUM_IN_W) sum = sum - NUM_IN_W;
      if (!found && in_req_i[sum[IdxWidth-1:0]]) begin
        found   = 1'b1;
        win_idx = sum[IdxWidth-1:0];
      end
    end
  end

  assign out_req_o = |in_req_i;
  assign hs        = out_req_o & out_gnt_i;
  assign win_req   = found ? lane_req[win_idx] : '0;

  assign out_add_o   = win_req.add;
  assign out_amo_o   = win_req.amo;
  assign out_wen_o   = win_req.wen;
  assign out_wdata_o = win_req.wdata;
  assign out_be_o    = win_req.be;

  assign in_gnt_o = hs ? (NumIn'(1) << win_idx) : '0;

  // Next pointer is one past the winner, modulo NumIn.
  always_comb begin
    ptr_inc = {1'b0, win_idx} + (IdxWidth+1)'(1);
    if (ptr_inc >= NUM_IN_W) ptr_inc = '0;
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    rvalid_d  = hs;
    rsp_idx_d = rsp_idx_q;
    state_d   = state_q;
    if (hs) begin
      rr_ptr_d  = ptr_inc[IdxWidth-1:0];
      rsp_idx_d = win_idx;
    end
    case (state_q)
      Idle:      if (hs && (out_amo_o != 4'd0)) state_d = AmoCommit;
      AmoCommit: state_d = Idle;
      default:   state_d = Idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q  <= '0;
      rvalid_q  <= 1'b0;
      rsp_idx_q <= '0;
      state_q   <= Idle;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      rvalid_q  <= rvalid_d;
      rsp_idx_q <= rsp_idx_d;
      state_q   <= state_d;
    end
  end

  // A response still in flight when reset arrives is suppressed in that very
  // cycle, so the requester never sees an rvalid that belongs to a dead epoch.
  assign in_rvalid_o = rst_i ? '0 : (NumIn'(rvalid_q) << rsp_idx_q);
  assign in_rdata_o  = out_rdata_i;

`ifndef SYNTHESIS
  // The shim owns the bank while it writes back an AMO result.
  always_ff @(posedge clk_i) begin
    if (!rst_i && state_q == AmoCommit) assert (!out_gnt_i);
  end
`endif

`ifdef AMO_BANK_ARB_PERF_EN
  logic [31:0] perf_grants_q, perf_stalls_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_grants_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (hs && perf_grants_q != 32'hFFFF_FFFF) perf_grants_q <= perf_grants_q + 32'd1;
      if (out_req_o && !out_gnt_i && perf_stalls_q != 32'hFFFF_FFFF)
        perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_grants_o = perf_grants_q;
  assign perf_stalls_o = perf_stalls_q;
`endif

endmodule

// File: tb/tb_amo_bank_arbiter.sv
// Directed bench for amo_bank_arbiter (NumIn=4, 32-bit address, 64-bit data).
// A small behavioural shim holds a 256-word memory, returns read data one
// cycle after each grant and drops its grant for one cycle to commit an AMO
// (opcode 2 = add, any other nonzero opcode = swap). Inputs change on the
// falling edge; outputs are sampled 1 time unit later.

module tb_amo_bank_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req;
  logic [3:0]       gnt;
  logic [3:0][31:0] add;
  logic [3:0][3:0]  amo;
  logic [3:0]       wen;
  logic [3:0][63:0] wdata;
  logic [3:0][7:0]  be;
  logic [3:0]       rvalid;
  logic [63:0]      rdata;
  logic             out_req;
  logic             out_gnt;
  logic [31:0]      out_add;
  logic [3:0]       out_amo;
  logic             out_wen;
  logic [63:0]      out_wdata;
  logic [7:0]       out_be;
  logic [63:0]      shim_rdata;
`ifdef AMO_BANK_ARB_PERF_EN
  logic [31:0]      perf_grants;
  logic [31:0]      perf_stalls;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  amo_bank_arbiter #(.NumIn(4), .AddrMemWidth(32), .DataWidth(64)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_req_i    (req),
    .in_gnt_o    (gnt),
    .in_add_i    (add),
    .in_amo_i    (amo),
    .in_wen_i    (wen),
    .in_wdata_i  (wdata),
    .in_be_i     (be),
    .in_rvalid_o (rvalid),
    .in_rdata_o  (rdata),
    .out_req_o   (out_req),
    .out_gnt_i   (out_gnt),
    .out_add_o   (out_add),
    .out_amo_o   (out_amo),
    .out_wen_o   (out_wen),
    .out_wdata_o (out_wdata),
    .out_be_o    (out_be),
    .out_rdata_i (shim_rdata)
`ifdef AMO_BANK_ARB_PERF_EN
    ,
    .perf_grants_o (perf_grants),
    .perf_stalls_o (perf_stalls)
`endif
  );

  // ---- shim model ----
  logic [63:0] mem [0:255];
  logic        init;
  logic        gnt_en;
  logic        amo_pend = 1'b0;
  logic [7:0]  amo_add;
  logic [3:0]  amo_op;
  logic [63:0] amo_opnd;

  assign out_gnt = gnt_en & ~amo_pend;

  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 64'h1000 + 64'(i);
      mem[4]     <= 64'd7;
      amo_pend   <= 1'b0;
      shim_rdata <= '0;
    end else if (amo_pend) begin
      mem[amo_add] <= (amo_op == 4'd2) ? mem[amo_add] + amo_opnd : amo_opnd;
      amo_pend     <= 1'b0;
    end else if (out_req && out_gnt) begin
      shim_rdata <= mem[out_add[7:0]];
      if (out_amo != 4'd0) begin
        amo_pend <= 1'b1;
        amo_add  <= out_add[7:0];
        amo_op   <= out_amo;
        amo_opnd <= out_wdata;
      end else if (out_wen) begin
        mem[out_add[7:0]] <= out_wdata;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; init = 1'b1; gnt_en = 1'b1;
    req = '0; add = '0; amo = '0; wen = '0; wdata = '0; be = '1;
    repeat (2) @(negedge clk);
    init = 1'b0;
    #1;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_rvalid", rvalid, 4'b0000);
    chk("rst_outreq", out_req, 1'b0);
    chk("rst_outadd", out_add, 32'h0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rel_rvalid", rvalid, 4'b0000);

    // Single load from requester 2
    @(negedge clk); req = 4'b0100; add[2] = 32'h10;
    #1;
    chk("ld_gnt", gnt, 4'b0100);
    chk("ld_outadd", out_add, 32'h10);
    chk("ld_outreq", out_req, 1'b1);
    // pointer now 3: requester 3 beats requester 0
    @(negedge clk); req = 4'b1001; add[3] = 32'h20;
    #1;
    chk("ld_rvalid", rvalid, 4'b0100);
    chk("ld_rdata", rdata, 64'h1010);
    chk("ptr3_gnt", gnt, 4'b1000);
    @(negedge clk); req = 4'b0000;
    #1;
    chk("ptr3_rvalid", rvalid, 4'b1000);
    chk("ptr3_rdata", rdata, 64'h1020);

    // Fairness: all four hold loads, pointer starts at 0
    for (int i = 0; i < 4; i++) add[i] = 32'h30 + 32'(i);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); req = 4'b1111;
      #1;
      chk("fair_gnt", gnt, 4'b0001 << (k % 4));
      if (k > 0) begin
        chk("fair_rvalid", rvalid, 4'b0001 << ((k - 1) % 4));
        chk("fair_rdata", rdata, 64'h1030 + 64'((k - 1) % 4));
      end
    end
    @(negedge clk); req = 4'b0000;
    #1;
    chk("fair_last_rvalid", rvalid, 4'b1000);
    chk("fair_last_rdata", rdata, 64'h1033);

    // AMO add on requester 0 while requester 1 loads
    @(negedge clk); req = 4'b0011; amo[0] = 4'd2; add[0] = 32'h4; wdata[0] = 64'd5; add[1] = 32'h11;
    #1;
    chk("amo_gnt", gnt, 4'b0001);
    chk("amo_outamo", out_amo, 4'd2);
    chk("amo_outwdata", out_wdata, 64'd5);
    @(negedge clk); req = 4'b0010; amo[0] = 4'd0;
    #1;
    chk("amo_commit_gnt", gnt, 4'b0000);
    chk("amo_commit_outreq", out_req, 1'b1);
    chk("amo_rvalid", rvalid, 4'b0001);
    chk("amo_rdata", rdata, 64'd7);
    @(negedge clk);
    #1;
    chk("amo_next_gnt", gnt, 4'b0010);
    chk("amo_next_rvalid", rvalid, 4'b0000);
    chk("amo_mem", mem[4], 64'd12);
    // pointer is 2; lone requester 0 wins, pointer becomes 1
    @(negedge clk); req = 4'b0001; add[0] = 32'h12;
    #1;
    chk("amo_ld_rvalid", rvalid, 4'b0010);
    chk("amo_ld_rdata", rdata, 64'h1011);
    chk("wrap_gnt", gnt, 4'b0001);

    // Shim stall for 3 cycles with pointer at 1
    @(negedge clk); req = 4'b1010; gnt_en = 1'b0; add[1] = 32'h40; add[3] = 32'h43;
    #1;
    chk("wrap_rvalid", rvalid, 4'b0001);
    chk("wrap_rdata", rdata, 64'h1012);
    chk("stall_gnt", gnt, 4'b0000);
    chk("stall_outadd", out_add, 32'h40);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk("stall_gnt", gnt, 4'b0000);
      chk("stall_rvalid", rvalid, 4'b0000);
    end
    @(negedge clk); gnt_en = 1'b1;
    #1;
    chk("stall_end_gnt", gnt, 4'b0010);
    @(negedge clk); req = 4'b1000;
    #1;
    chk("stall_rvalid1", rvalid, 4'b0010);
    chk("stall_rdata1", rdata, 64'h1040);
    chk("stall_gnt3", gnt, 4'b1000);
    @(negedge clk); req = 4'b0000;
    #1;
    chk("stall_rvalid3", rvalid, 4'b1000);
    chk("stall_rdata3", rdata, 64'h1043);

    // Reset in the cycle after a grant to requester 2
    @(negedge clk); req = 4'b0100; add[2] = 32'h50;
    #1;
    chk("rstmid_gnt", gnt, 4'b0100);
    @(negedge clk); req = 4'b0000; rst = 1'b1;
    #1;
    chk("rstmid_rvalid", rvalid, 4'b0000);
    @(negedge clk); rst = 1'b0; req = 4'b1001; add[0] = 32'h60; add[3] = 32'h63;
    #1;
    chk("rstmid_rvalid2", rvalid, 4'b0000);
    chk("rstmid_ptr0_gnt", gnt, 4'b0001);
    @(negedge clk); req = 4'b0000;
    #1;
    chk("rstmid_after_rvalid", rvalid, 4'b0001);
    chk("rstmid_after_rdata", rdata, 64'h1060);

`ifdef AMO_BANK_ARB_PERF_EN
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; req = 4'b0001; gnt_en = 1'b0;
    @(negedge clk);
    @(negedge clk); gnt_en = 1'b1; req = 4'b1111;
    repeat (4) @(negedge clk);
    req = 4'b0000;
    #1;
    chk("perf_grants", perf_grants, 32'd4);
    chk("perf_stalls", perf_stalls, 32'd2);
    @(negedge clk); force dut.perf_stalls_q = 32'hFFFF_FFFF; gnt_en = 1'b0; req = 4'b0001;
    #1;
    release dut.perf_stalls_q;
    @(negedge clk); req = 4'b0000; gnt_en = 1'b1;
    #1;
    chk("perf_stalls_sat", perf_stalls, 32'hFFFF_FFFF);
    chk("perf_grants_hold", perf_grants, 32'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
